hcsr04_scan_sched: RTL and testbench

Round-robin measurement scheduler for a bank of HC-SR04 ultrasonic rangers that share one echo-timing datapath. For each enabled sensor it issues a trigger pulse, times the echo pulse in microseconds, enforces a timeout and an inter-ping guard interval, then moves to the next sensor. It sits between the sensor pins and the HCRS04 AXI4-Lite register file: the register file supplies `run` and `enable_mask`, and captures each `sample_*` strobe into a per-sensor distance register.

---
 rtl/hcsr04_pkg.sv | 27 ++
 rtl/hcsr04_echo_sync.sv | 29 ++
 rtl/hcsr04_scan_sched.sv | 171 +++++++++++++++++
 tb/tb_hcsr04_scan_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared types for the HC-SR04 scan scheduler: FSM states, result bundle,
// and the index-width helper used to size sensor-index ports.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GUARD
  } state_t;

  // Result fields are sized for the largest supported bank (8 sensors, 32-bit counter).
  localparam int IDX_MAX_W = 3;
  localparam int US_MAX_W  = 32;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic [US_MAX_W-1:0]  us;
    logic                 timeout;
  } sample_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hcsr04_echo_sync.sv
// One echo pin: two-flop synchronizer followed by an edge-detect register.
module hcsr04_echo_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/hcsr04_scan_sched.sv
// Round-robin HC-SR04 scheduler: trigger, time the echo in microseconds,
// apply timeout and guard interval, then move to the next enabled sensor.
module hcsr04_scan_sched
  import hcsr04_pkg::*;
#(
  parameter  int N_SENSORS       = 4,
  parameter  int CLK_DIV         = 100,
  parameter  int TRIG_US         = 10,
  parameter  int ECHO_TIMEOUT_US = 30000,
  parameter  int GUARD_US        = 60000,
  parameter  int CNT_W           = 16,
  localparam int IDX_W           = idx_width(N_SENSORS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [N_SENSORS-1:0] enable_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 busy,
  output logic                 sample_valid,
  output logic [IDX_W-1:0]     sample_idx,
  output logic [CNT_W-1:0]     sample_us,
  output logic                 sample_timeout
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     cur_idx_reg, cur_idx_next;
  logic [PRE_W-1:0]     presc_reg, presc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [N_SENSORS-1:0] trig_reg, trig_next;
  logic [N_SENSORS-1:0] rise_vec, fall_vec;
  logic                 sample_valid_reg, sample_valid_next;
  sample_t              sample_reg, sample_next;
  logic                 tick, rise_sel, fall_sel, entering, can_start;
  logic                 unused_sample_bits;

  genvar gi;
  generate
    for (gi = 0; gi < N_SENSORS; gi++) begin : g_sync
      hcsr04_echo_sync sync (
        .clock (clock),
        .reset (reset),
        .din   (echo[gi]),
        .rise  (rise_vec[gi]),
        .fall  (fall_vec[gi])
      );
    end
  endgenerate

  assign rise_sel  = rise_vec[cur_idx_reg];
  assign fall_sel  = fall_vec[cur_idx_reg];
  assign tick      = (presc_reg == PRE_W'(CLK_DIV - 1));
  assign can_start = run && (|enable_mask);
  assign entering  = (state_next != state_reg);

  // First enabled sensor strictly after cur, wrapping; cur itself is the last candidate.
  function automatic logic [IDX_W-1:0] rr_next(input logic [N_SENSORS-1:0] mask,
                                               input logic [IDX_W-1:0]     cur);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = cur;
    for (int i = N_SENSORS; i >= 1; i--) begin
      cand = IDX_W'((int'(cur) + i) % N_SENSORS);
      if (mask[cand]) pick = cand;
    end
    return pick;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cur_idx_reg <= IDX_W'(N_SENSORS - 1);
    end else begin
      state_reg   <= state_next;
      cur_idx_reg <= cur_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_idx_next = cur_idx_reg;
    case (state_reg)
      IDLE: begin
        if (can_start) begin
          state_next   = TRIG;
          cur_idx_next = rr_next(enable_mask, cur_idx_reg);
        end
      end
      TRIG: begin
        if (tick && cnt_reg == CNT_W'(TRIG_US - 1)) state_next = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise_sel) state_next = MEASURE;
        else if (tick && cnt_reg == CNT_W'(ECHO_TIMEOUT_US - 1)) state_next = GUARD;
      end
      MEASURE: begin
        if (fall_sel || (tick && cnt_reg == CNT_W'(ECHO_TIMEOUT_US - 1))) state_next = GUARD;
      end
      GUARD: begin
        if (tick && cnt_reg == CNT_W'(GUARD_US - 1)) begin
          if (can_start) begin
            state_next   = TRIG;
            cur_idx_next = rr_next(enable_mask, cur_idx_reg);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    trig_next = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      trig_next[i] = (state_next == TRIG) && (cur_idx_next == IDX_W'(i));
    end
    sample_valid_next = (state_next == GUARD) && (state_reg != GUARD);
    sample_next       = sample_reg;
    if (sample_valid_next) begin
      sample_next.idx = IDX_MAX_W'(cur_idx_reg);
      if (state_reg == WAIT_RISE) begin
        sample_next.us      = '0;
        sample_next.timeout = 1'b1;
      end else if (fall_sel) begin
        sample_next.us      = US_MAX_W'(cnt_reg);
        sample_next.timeout = 1'b0;
      end else begin
        sample_next.us      = US_MAX_W'(ECHO_TIMEOUT_US);
        sample_next.timeout = 1'b1;
      end
    end
  end

  // Every phase restarts its timebase on entry so durations are exact multiples of CLK_DIV.
  always_comb begin
    presc_next = presc_reg + PRE_W'(1);
    cnt_next   = cnt_reg;
    if (state_reg == IDLE || entering || tick) presc_next = '0;
    if (entering) cnt_next = '0;
    else if (tick) cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_reg        <= '0;
      cnt_reg          <= '0;
      trig_reg         <= '0;
      sample_valid_reg <= 1'b0;
      sample_reg       <= '0;
    end else begin
      presc_reg        <= presc_next;
      cnt_reg          <= cnt_next;
      trig_reg         <= trig_next;
      sample_valid_reg <= sample_valid_next;
      sample_reg       <= sample_next;
    end
  end

  assign trig               = trig_reg;
  assign busy               = (state_reg != IDLE);
  assign sample_valid       = sample_valid_reg;
  assign sample_idx         = sample_reg.idx[IDX_W-1:0];
  assign sample_us          = sample_reg.us[CNT_W-1:0];
  assign sample_timeout     = sample_reg.timeout;
  assign unused_sample_bits = ^sample_reg;

endmodule

// File: tb/tb_hcsr04_scan_sched.sv
// Scoreboard bench: a sensor model drives echo pulses per trigger and queues the
// expected result; a monitor pops and compares on every sample strobe.
module tb_hcsr04_scan_sched;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int TU = 3;
  localparam int TO = 50;
  localparam int GU = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [N-1:0]  mask = '0;
  logic [N-1:0]  echo;
  logic [N-1:0]  trig;
  logic          busy;
  logic          sample_valid;
  logic [1:0]    sample_idx;
  logic [CW-1:0] sample_us;
  logic          sample_timeout;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int idx;
    int us;
    int to;
    int tol;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  longint es[N] = '{default: 0};
  longint ee[N] = '{default: 0};
  int     prev_idx = N - 1;

  hcsr04_scan_sched #(
    .N_SENSORS       (N),
    .CLK_DIV         (CD),
    .TRIG_US         (TU),
    .ECHO_TIMEOUT_US (TO),
    .GUARD_US        (GU),
    .CNT_W           (CW)
  ) dut (
    .clock          (clk),
    .reset          (rst),
    .run            (run),
    .enable_mask    (mask),
    .echo           (echo),
    .trig           (trig),
    .busy           (busy),
    .sample_valid   (sample_valid),
    .sample_idx     (sample_idx),
    .sample_us      (sample_us),
    .sample_timeout (sample_timeout)
  );

  always #5 clk = ~clk;

  // Echo pins follow the scheduled [start, end) windows, updated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) echo[i] = (cyc >= es[i]) && (cyc < ee[i]);
  end

  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_sample: idx=%0d us=%0d timeout=%0d with nothing queued",
                 sample_idx, sample_us, sample_timeout);
      end else begin
        exp_t e;
        int   diff;
        e    = sb.pop_front();
        diff = int'(sample_us) - e.us;
        if (int'(sample_idx) != e.idx || int'(sample_timeout) != e.to || diff > e.tol || diff < -e.tol) begin
          miscompares++;
          $display("FAIL sample: got idx=%0d us=%0d timeout=%0d, expected idx=%0d us=%0d(+-%0d) timeout=%0d",
                   sample_idx, sample_us, sample_timeout, e.idx, e.us, e.tol, e.to);
        end else begin
          $display("sample ok: idx=%0d us=%0d timeout=%0d", sample_idx, sample_us, sample_timeout);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check ok: %s = %0d", name, act);
    end
  endtask

  // Reference selection: next enabled sensor after the previous one, wrapping.
  function automatic int rr_model(input logic [N-1:0] m, input int p);
    for (int i = 1; i <= N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return p;
  endfunction

  // kind 0: normal echo (delay d us, width w us); 1: no echo; 2: over-long echo of w us.
  task automatic measure(input int kind, input int d, input int w, input bit stop_mid);
    int     t;
    int     len;
    int     idx;
    int     exp_idx;
    longint now;
    exp_t   e;
    t = 0;
    @(negedge clk);
    while (trig == '0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (trig == '0) begin
      vectors++;
      miscompares++;
      $display("FAIL trig_wait: no trigger within %0d cycles, required one", t);
      return;
    end
    exp_idx  = rr_model(mask, prev_idx);
    prev_idx = exp_idx;
    idx      = 0;
    for (int i = 0; i < N; i++) if (trig[i]) idx = i;
    check("trig_onehot", $countones(trig), 1);
    check("trig_idx", idx, exp_idx);
    check("busy_in_trig", busy, 1);
    len = 0;
    while (trig != '0 && len < 100) begin
      len++;
      @(negedge clk);
    end
    check("trig_len", len, TU * CD);
    now   = cyc;
    e.idx = exp_idx;
    case (kind)
      0: begin
        es[idx] = now + d * CD;
        ee[idx] = es[idx] + w * CD;
        e.us = w; e.to = 0; e.tol = 1;
      end
      1: begin
        e.us = 0; e.to = 1; e.tol = 0;
      end
      default: begin
        es[idx] = now + d * CD;
        ee[idx] = es[idx] + w * CD;
        e.us = TO; e.to = 1; e.tol = 0;
      end
    endcase
    sb.push_back(e);
    $display("issue: sensor=%0d kind=%0d delay=%0d width=%0d", idx, kind, d, w);
    if (stop_mid) begin
      while (cyc < es[idx] + 20) @(negedge clk);
      run = 1'b0;
    end
  endtask

  task automatic random_measure();
    int k;
    k = $urandom_range(0, 2);
    if (k == 0) measure(0, $urandom_range(1, 30), $urandom_range(2, 45), 1'b0);
    else if (k == 1) measure(1, 0, 0, 1'b0);
    else measure(2, $urandom_range(1, 10), $urandom_range(55, 68), 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_us", sample_us, 0);
    check("rst_timeout", sample_timeout, 0);

    rst  = 1'b0;
    mask = 4'b1111;
    run  = 1'b1;
    measure(0, 5, 25, 1'b0);
    measure(1, 0, 0, 1'b0);
    measure(2, 5, 80, 1'b0);
    repeat (8) random_measure();

    measure(0, 3, 30, 1'b1);
    wait_idle("idle_after_stop");
    check("sb_drained_stop", sb.size(), 0);
    repeat (50) @(negedge clk);
    check("idle_trig", trig, 0);

    mask = 4'b0000;
    run  = 1'b1;
    repeat (200) @(negedge clk);
    check("mask0_busy", busy, 0);
    check("mask0_trig", trig, 0);

    mask = 4'b1010;
    repeat (6) random_measure();
    run = 1'b0;
    wait_idle("idle_after_1010");

    mask = 4'b0100;
    run  = 1'b1;
    repeat (3) random_measure();
    run = 1'b0;
    wait_idle("idle_after_single");

    for (int r = 0; r < 3; r++) begin
      mask = 4'($urandom_range(1, 15));
      run  = 1'b1;
      repeat (4) random_measure();
      run = 1'b0;
      wait_idle("idle_after_random_mask");
    end
    check("sb_drained_end", sb.size(), 0);

    // Reset mid-trigger must clear outputs without waiting for a clock edge.
    mask = 4'b1111;
    run  = 1'b1;
    begin
      int t;
      t = 0;
      while (trig == '0 && t < 4000) begin
        @(negedge clk);
        t++;
      end
    end
    check("pre_reset_trig_active", (trig != '0), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_trig", trig, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", sample_valid, 0);
    check("async_rst_idx", sample_idx, 0);
    check("async_rst_us", sample_us, 0);
    check("async_rst_timeout", sample_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
